// File: rtl/audio_pkg.sv
// Shared types and defaults for the audio playback buffer.
package audio_pkg;

  typedef enum logic {FILL, PLAY} state_e;

  localparam logic [7:0] SILENCE = 8'h80;

  localparam int unsigned DEFAULT_DEPTH_LOG2 = 11;
  localparam int unsigned DEFAULT_TICK_DIV   = 6250;
  localparam int unsigned DEFAULT_PREFILL    = 1024;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/audio_pwm.sv
// 8-bit PWM modulator: pwm_out is high for `sample` out of every 256 cycles.
module audio_pwm
  import audio_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sample,
  output logic       pwm_out
);

  logic [7:0] pwm_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_cnt_q <= 8'd0;
      pwm_out   <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
      pwm_out   <= (pwm_cnt_q < sample);
    end
  end

endmodule

// File: rtl/audio_playback_buffer.sv
// Circular FIFO that prefills, then releases one PCM byte per sample tick.
// Define AUDIO_PWM_EN to drive pwm_out from an on-chip PWM modulator.
module audio_playback_buffer
  import audio_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
  parameter int unsigned TICK_DIV   = DEFAULT_TICK_DIV,
  parameter int unsigned PREFILL    = DEFAULT_PREFILL
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                audio_axiiv,
  input  logic [7:0]          audio_axiid,
  output logic                sample_valid,
  output logic [7:0]          sample_out,
  output logic [DEPTH_LOG2:0] level,
  output logic                playing,
  output logic [15:0]         overflow_count,
  output logic [15:0]         underrun_count,
  output logic                pwm_out
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned PtrW  = DEPTH_LOG2 + 1;
  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [7:0]       mem [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [TickW-1:0] tick_cnt_q;
  state_e           state_q;
  logic             full, empty, tick, wr_en;

  // Extra pointer bit distinguishes full from empty.
  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == PtrW'(Depth));
  assign empty = (level == '0);
  assign tick  = (tick_cnt_q == TickW'(TICK_DIV - 1));
  assign wr_en = audio_axiiv && !full;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= audio_axiid;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q       <= '0;
      overflow_count <= 16'd0;
    end else if (audio_axiiv) begin
      if (!full) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      else       overflow_count <= sat_inc16(overflow_count);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + TickW'(1);
    end
  end

  // sample_out doubles as the BRAM read register, so data lands in tick+1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= FILL;
      playing        <= 1'b0;
      rd_ptr_q       <= '0;
      sample_valid   <= 1'b0;
      sample_out     <= SILENCE;
      underrun_count <= 16'd0;
    end else begin
      sample_valid <= 1'b0;
      unique case (state_q)
        FILL: begin
          if (level >= PtrW'(PREFILL)) begin
            state_q <= PLAY;
            playing <= 1'b1;
          end
        end
        PLAY: begin
          if (tick) begin
            sample_valid <= 1'b1;
            if (!empty) begin
              sample_out <= mem[rd_ptr_q[DEPTH_LOG2-1:0]];
              rd_ptr_q   <= rd_ptr_q + PtrW'(1);
            end else begin
              sample_out     <= SILENCE;
              underrun_count <= sat_inc16(underrun_count);
              state_q        <= FILL;
              playing        <= 1'b0;
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

`ifdef AUDIO_PWM_EN
  audio_pwm u_pwm (
    .clk     (clk),
    .rst     (rst),
    .sample  (sample_out),
    .pwm_out (pwm_out)
  );
`else
  assign pwm_out = 1'b0;
`endif

endmodule

// File: tb/tb_audio_playback_buffer.sv
// Directed bench: a fast-tick instance for playback/underrun, a default instance for overflow/PWM.
module tb_audio_playback_buffer;
  import audio_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Fast instance, TICK_DIV = 16
  logic        rst_f, axiiv_f;
  logic [7:0]  axiid_f, so_f;
  logic        sv_f, play_f, pwm_f;
  logic [11:0] lvl_f;
  logic [15:0] ovf_f, und_f;

  // Default-parameter instance
  logic        rst_d, axiiv_d;
  logic [7:0]  axiid_d, so_d;
  logic        sv_d, play_d, pwm_d;
  logic [11:0] lvl_d;
  logic [15:0] ovf_d, und_d;

  audio_playback_buffer #(.TICK_DIV(16)) u_fast (
    .clk            (clk),
    .rst            (rst_f),
    .audio_axiiv    (axiiv_f),
    .audio_axiid    (axiid_f),
    .sample_valid   (sv_f),
    .sample_out     (so_f),
    .level          (lvl_f),
    .playing        (play_f),
    .overflow_count (ovf_f),
    .underrun_count (und_f),
    .pwm_out        (pwm_f)
  );

  audio_playback_buffer u_dflt (
    .clk            (clk),
    .rst            (rst_d),
    .audio_axiiv    (axiiv_d),
    .audio_axiid    (axiid_d),
    .sample_valid   (sv_d),
    .sample_out     (so_d),
    .level          (lvl_d),
    .playing        (play_d),
    .overflow_count (ovf_d),
    .underrun_count (und_d),
    .pwm_out        (pwm_d)
  );

  int checks = 0;
  int errors = 0;

  // Independent model of the fast instance's tick phase.
  int tcnt;
  always @(posedge clk or negedge rst_f) begin
    if (!rst_f) tcnt <= 0;
    else        tcnt <= (tcnt == 15) ? 0 : tcnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_sv_f(input int budget);
    int n = 0;
    while (!sv_f && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("fast_valid_seen", 32'(sv_f), 32'd1);
  endtask

  task automatic wait_sv_d(input int budget);
    int n = 0;
    while (!sv_d && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("dflt_valid_seen", 32'(sv_d), 32'd1);
  endtask

  initial begin
    int pulses;
    int lvl_before;
    int hi;
    logic [7:0] expb;

    rst_f = 1'b0; axiiv_f = 1'b0; axiid_f = 8'h00;
    rst_d = 1'b0; axiiv_d = 1'b0; axiid_d = 8'h00;
    repeat (3) @(negedge clk);

    // Idle after reset: silence, nothing buffered, no pulses
    rst_f = 1'b1;
    pulses = 0;
    repeat (48) begin
      @(negedge clk);
      pulses += int'(sv_f);
    end
    check_eq("idle_pulses", 32'(pulses), 32'd0);
    check_eq("idle_sample", 32'(so_f), 32'h80);
    check_eq("idle_level", 32'(lvl_f), 32'd0);
    check_eq("idle_playing", 32'(play_f), 32'd0);
    check_eq("idle_ovf", 32'(ovf_f), 32'd0);
    check_eq("idle_und", 32'(und_f), 32'd0);
    check_eq("idle_pwm", 32'(pwm_f), 32'd0);

    // Prefill 1024 bytes, 0x00..0xFF repeating
    for (int i = 0; i < 1024; i++) begin
      axiiv_f = 1'b1;
      axiid_f = 8'(i);
      @(negedge clk);
    end
    axiiv_f = 1'b0;
    check_eq("prefill_level", 32'(lvl_f), 32'd1024);
    check_eq("prefill_playing_lag", 32'(play_f), 32'd0);
    @(negedge clk);
    check_eq("prefill_playing", 32'(play_f), 32'd1);

    // Play back all 1024 bytes plus one written in a tick cycle
    for (int n = 0; n < 1025; n++) begin
      if (n == 11) begin
        int k = 0;
        while (tcnt != 15 && k < 32) begin
          @(negedge clk);
          k++;
        end
        lvl_before = int'(lvl_f);
        axiiv_f = 1'b1;
        axiid_f = 8'hA5;
        @(negedge clk);
        axiiv_f = 1'b0;
        check_eq("tick_write_level", 32'(lvl_f), 32'(lvl_before));
      end
      expb = (n < 1024) ? 8'(n) : 8'hA5;
      wait_sv_f(40);
      check_eq("play_sample", 32'(so_f), 32'(expb));
      if (n < 4) check_eq("play_phase", 32'(tcnt), 32'd0);
      @(negedge clk);
    end
    check_eq("drained_level", 32'(lvl_f), 32'd0);
    check_eq("drained_playing", 32'(play_f), 32'd1);

    // Next tick underruns
    wait_sv_f(40);
    check_eq("underrun_sample", 32'(so_f), 32'h80);
    check_eq("underrun_count", 32'(und_f), 32'd1);
    check_eq("underrun_playing", 32'(play_f), 32'd0);
    check_eq("underrun_ovf", 32'(ovf_f), 32'd0);

    // Overflow: 2050 bytes before the first tick of the default instance
    rst_d = 1'b1;
    for (int i = 0; i < 2050; i++) begin
      axiiv_d = 1'b1;
      axiid_d = 8'(i + 'h40);
      @(negedge clk);
    end
    axiiv_d = 1'b0;
    check_eq("ovf_level", 32'(lvl_d), 32'd2048);
    check_eq("ovf_count", 32'(ovf_d), 32'd2);
    check_eq("ovf_playing", 32'(play_d), 32'd1);
    wait_sv_d(7000);
    check_eq("ovf_first_sample", 32'(so_d), 32'h40);
    check_eq("ovf_level_after", 32'(lvl_d), 32'd2047);
    check_eq("ovf_und", 32'(und_d), 32'd0);

    // PWM duty with sample_out held at 0x40
    repeat (2) @(negedge clk);
    hi = 0;
    repeat (256) begin
      hi += int'(pwm_d);
      @(negedge clk);
    end
`ifdef AUDIO_PWM_EN
    check_eq("pwm_high_cycles", 32'(hi), 32'd64);
`else
    check_eq("pwm_high_cycles", 32'(hi), 32'd0);
`endif
    check_eq("pwm_hold_sample", 32'(so_d), 32'h40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
